// File: rtl/regfile_bypass_sb.sv
// Decode-stage register file: one write port, NUM_RD synchronous read ports,
// optional hard-wired zero register, optional write-to-read bypass, and a
// per-register busy scoreboard for RAW hazard detection.
module regfile_bypass_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wen,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     mark_en,
  input  logic [ADDR_W-1:0]        mark_addr,
  input  logic                     flush,
  output logic [2**ADDR_W-1:0]     busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_nxt;
  logic              wr_eff;

  // A write to register 0 is dropped entirely when it is hard-wired to zero.
  assign wr_eff = wen && !((ZERO_REG != 0) && (waddr == '0));

  // Scoreboard next state: a new mark beats a flush, which beats a retiring write.
  always_comb begin
    busy_nxt = busy_q;
    for (int a = 0; a < DEPTH; a++) begin
      if (mark_en && (mark_addr == ADDR_W'(a))) begin
        busy_nxt[a] = 1'b1;
      end else if (flush) begin
        busy_nxt[a] = 1'b0;
      end else if (wen && (waddr == ADDR_W'(a))) begin
        busy_nxt[a] = 1'b0;
      end
    end
    if (ZERO_REG != 0) begin
      busy_nxt[0] = 1'b0;
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  assign busy_vec = busy_q;

  // Register array write port.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem[a] <= '0;
      end
    end else if (wr_eff) begin
      mem[waddr] <= wdata;
    end
  end

  // One identical read slice per port; rdata and rbusy are registered together
  // so a forwarded value is reported with the busy state of the same edge.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd_sel;
    logic [DATA_W-1:0] rdata_p1;
    logic              rbusy_p1;

    assign ra = raddr[i*ADDR_W +: ADDR_W];

    // Read mux: array contents, optionally overridden by the in-flight write,
    // and forced to zero for the hard-wired register.
    always_comb begin
      rd_sel = mem[ra];
      if ((BYPASS != 0) && wr_eff && (waddr == ra)) begin
        rd_sel = wdata;
      end
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rd_sel = '0;
      end
    end

    // ---- stage p1: registered read data and busy flag ----
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        rdata_p1 <= '0;
        rbusy_p1 <= 1'b0;
      end else begin
        rdata_p1 <= rd_sel;
        rbusy_p1 <= busy_nxt[ra];
      end
    end

    assign rdata[i*DATA_W +: DATA_W] = rdata_p1;
    assign rbusy[i]                  = rbusy_p1;
  end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Directed bench for regfile_bypass_sb: default configuration, a 4-port
// variant, and a variant without zero register or bypass, all on shared stimulus.
module tb_regfile_bypass_sb;

  logic        clock = 1'b0;
  logic        reset;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [19:0] raddr4;
  logic        mark_en;
  logic [4:0]  mark_addr;
  logic        flush;

  logic [63:0]  rdata;
  logic [1:0]   rbusy;
  logic [31:0]  busy_vec;
  logic [127:0] rdata4;
  logic [3:0]   rbusy4;
  logic [31:0]  busy_vec4;
  logic [63:0]  rdatan;
  logic [1:0]   rbusyn;
  logic [31:0]  busy_vecn;

  int checks = 0;
  int failures = 0;

  assign raddr4 = {raddr, raddr};

  always #5 clock = ~clock;

  regfile_bypass_sb dut (
    .clock(clock), .reset(reset), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .mark_en(mark_en),
    .mark_addr(mark_addr), .flush(flush), .busy_vec(busy_vec)
  );

  regfile_bypass_sb #(.NUM_RD(4)) dut4 (
    .clock(clock), .reset(reset), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr4), .rdata(rdata4), .rbusy(rbusy4), .mark_en(mark_en),
    .mark_addr(mark_addr), .flush(flush), .busy_vec(busy_vec4)
  );

  regfile_bypass_sb #(.ZERO_REG(0), .BYPASS(0)) dutn (
    .clock(clock), .reset(reset), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdatan), .rbusy(rbusyn), .mark_en(mark_en),
    .mark_addr(mark_addr), .flush(flush), .busy_vec(busy_vecn)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wen = 1'b0; waddr = '0; wdata = '0; mark_en = 1'b0; mark_addr = '0; flush = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    raddr = '0;
    idle();
    tick();
    tick();
    check("reset_rdata", rdata, 64'h0);
    check("reset_busy", busy_vec, 32'h0);
    reset = 1'b1;

    // Reset/readback: write 7, mark it busy, then reset mid-run
    wen = 1'b1; waddr = 5'd7; wdata = 32'h0000DEAD;
    tick();
    idle(); raddr = {5'd0, 5'd7};
    tick();
    check("pre_reset_rd7", rdata[31:0], 64'hDEAD);
    mark_en = 1'b1; mark_addr = 5'd7;
    tick();
    idle();
    check("pre_reset_busy7", busy_vec, 32'h80);
    #2 reset = 1'b0;
    #1;
    check("async_rdata", rdata[31:0], 64'h0);
    check("async_busy", busy_vec, 32'h0);
    tick();
    check("held_rdata", rdata[31:0], 64'h0);
    reset = 1'b1;
    tick();
    check("post_reset_rd7", rdata[31:0], 64'h0);
    check("post_reset_busy", busy_vec, 32'h0);

    // Write sweep
    for (int a = 0; a < 32; a++) begin
      wen = 1'b1; waddr = 5'(a); wdata = 32'(a + 1); raddr = '0;
      tick();
      idle(); raddr = {5'(a), 5'(a)};
      tick();
      check($sformatf("sweep_p0_%0d", a), rdata[31:0], (a == 0) ? 64'h0 : 64'(a + 1));
      check($sformatf("sweep_p1_%0d", a), rdata[63:32], (a == 0) ? 64'h0 : 64'(a + 1));
      check($sformatf("sweep4_p3_%0d", a), rdata4[127:96], (a == 0) ? 64'h0 : 64'(a + 1));
      check($sformatf("sweepn_p0_%0d", a), rdatan[31:0], 64'(a + 1));
    end

    // Bypass
    wen = 1'b1; waddr = 5'd6; wdata = 32'hAA;
    tick();
    wen = 1'b1; waddr = 5'd5; wdata = 32'h12345678; raddr = {5'd6, 5'd5};
    tick();
    check("byp_p0", rdata[31:0], 64'h12345678);
    check("byp_p1", rdata[63:32], 64'hAA);
    check("nobyp_p0", rdatan[31:0], 64'h6);
    check("nobyp_p1", rdatan[63:32], 64'hAA);
    idle();
    tick();
    check("nobyp_after", rdatan[31:0], 64'h12345678);

    // Scoreboard
    mark_en = 1'b1; mark_addr = 5'd9; raddr = {5'd9, 5'd9};
    tick();
    check("mark9_rbusy", rbusy, 64'h3);
    check("mark9_vec", busy_vec, 32'h200);
    idle(); wen = 1'b1; waddr = 5'd9; wdata = 32'h99;
    tick();
    check("wr9_vec", busy_vec, 32'h0);
    check("wr9_rbusy", rbusy, 64'h0);
    check("wr9_byp", rdata[31:0], 64'h99);
    wen = 1'b1; waddr = 5'd9; wdata = 32'h1234; mark_en = 1'b1; mark_addr = 5'd9;
    tick();
    check("markwr9_vec", busy_vec, 32'h200);
    check("markwr9_rbusy", rbusy, 64'h3);
    idle();
    tick();
    check("markwr9_mem", rdata[31:0], 64'h1234);
    check("markwr9_hold", busy_vec, 32'h200);

    // Flush
    mark_en = 1'b1; mark_addr = 5'd3;
    tick();
    mark_addr = 5'd4;
    tick();
    mark_addr = 5'd8;
    tick();
    check("pre_flush_vec", busy_vec, 32'h318);
    mark_addr = 5'd12; flush = 1'b1;
    tick();
    idle();
    check("flush_vec", busy_vec, 32'h1000);
    check("flush_vecn", busy_vecn, 32'h1000);

    // Zero register
    mark_en = 1'b1; mark_addr = 5'd0; raddr = '0;
    tick();
    check("zero_mark_vec", busy_vec, 32'h1000);
    check("zero_mark_vec4", busy_vec4, 32'h1000);
    check("zero_mark_vecn", busy_vecn, 32'h1001);
    check("zero_mark_rbusy", rbusy, 64'h0);
    idle(); wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    tick();
    check("zero_wr_rd", rdata, 64'h0);
    check("zero_wr_rd4", rdata4[63:0], 64'h0);
    check("zero_wr_rd4hi", rdata4[127:64], 64'h0);
    check("zero_wr_vecn", busy_vecn, 32'h1000);
    check("zero_wr_rdn", rdatan[31:0], 64'h1);
    idle();
    tick();
    check("zero_after_rd", rdata, 64'h0);
    check("zero_after_rd4", rdata4[127:64], 64'h0);
    check("zero_after_vec", busy_vec[0], 64'h0);
    check("zero_after_rdn", rdatan[31:0], 64'hFFFFFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_bypass_sb.md
Name: regfile_bypass_sb

Overview:
- Parametrised multi-read-port register file with a single write port, for the decode stage.
- Successor to the fixed 32x32, 2-read-port file: port count and width are generic, the zero register is optional, and reads are synchronous.
- Adds write-to-read bypass and a per-register busy scoreboard so decode can detect RAW hazards against in-flight producers.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, if 1, register 0 reads as 0, ignores writes and is never busy.
- BYPASS, 1, if 1, a same-cycle write to a read address forwards wdata to that port.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wen  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- raddr  in  NUM_RD*ADDR_W  read addresses; port i is bits [i*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  registered read data, port i at [i*DATA_W +: DATA_W].
- rbusy  out  NUM_RD  registered busy flag of each read port's address.
- mark_en  in  1  issue a new producer: set the busy bit of mark_addr.
- mark_addr  in  ADDR_W  destination register being issued.
- flush  in  1  synchronous clear of all busy bits.
- busy_vec  out  2**ADDR_W  current scoreboard contents, direct from the flops.

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers, rdata, rbusy and busy_vec go to 0 immediately.
  - They hold 0 while reset is low.
  - The first rising edge after deassertion operates normally.
- Write: at a rising edge with wen=1, mem[waddr] <= wdata, except waddr=0 when ZERO_REG=1 (ignored).
- Read latency is 1 cycle. At each rising edge, for each port i:
  - rdata_i <= mem[raddr_i].
  - If BYPASS=1 and wen=1 and waddr==raddr_i (and the address is not the suppressed zero register), rdata_i <= wdata instead.
  - If BYPASS=0, the same case returns the old contents.
  - If ZERO_REG=1 and raddr_i==0, rdata_i <= 0.
- Scoreboard busy bit b[a], priority per rising edge, highest first:
  1. mark_en=1 and mark_addr==a: b[a] <= 1.
  2. flush=1: b[a] <= 0.
  3. wen=1 and waddr==a: b[a] <= 0.
  4. otherwise hold.
  - A mark and a write to the same address in one cycle leave the bit set: the new producer supersedes the retiring one.
  - With ZERO_REG=1, b[0] is constant 0; a mark or write to address 0 does not change it.
- rbusy_i <= next-state value of b[raddr_i].
  - The busy flag is registered alongside rdata and reflects same-edge marks, clears and flushes.
  - This keeps rdata and rbusy coherent: a bypassed write reports not-busy unless re-marked in the same cycle.
- All read ports are independent. Identical addresses on several ports return identical data.
- Address wrap: none. Addresses are exactly ADDR_W bits; every value is legal.
- Outputs change only on a rising clock edge or on reset assertion; there are no combinational input-to-output paths.
- Synthesis target: mem as flops or distributed RAM. Port count is generated from NUM_RD, with no per-port hand code.

Test Plan:
- Reset/readback:
  - Assert reset=0 mid-run after writing mem[7]=0x0000DEAD, then release.
  - Read raddr0=7 → rdata0=0 and busy_vec=0.
- Write sweep:
  - For a=0..31 write value a+1, then read a on both ports one cycle later.
  - Ports 0/1 = a+1 for a>=1. Address 0 reads 0 (ZERO_REG=1); with ZERO_REG=0 it reads 1.
- Bypass:
  - Same cycle: wen=1, waddr=5, wdata=0x12345678, raddr0=5, raddr1=6 (mem[6]=0xAA).
  - Next cycle rdata0=0x12345678 and rdata1=0xAA.
  - With BYPASS=0, rdata0 = prior mem[5].
- Scoreboard:
  - mark_en at address 9 → next cycle rbusy=1 for a port reading 9, and busy_vec[9]=1.
  - Write 9 → busy_vec[9]=0.
  - Mark and write 9 in the same cycle → busy_vec[9] stays 1 and mem[9] is updated.
- Flush:
  - Mark 3, 4 and 8 over three cycles, then flush=1 together with mark_en at address 12.
  - busy_vec has only bit 12 set.
- Zero register:
  - mark_en at address 0, then write 0 with 0xFFFFFFFF.
  - busy_vec[0]=0 and rdata for address 0 is 0.
  - Repeat with NUM_RD=4, all ports reading 0, with the same result.
